// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state encodings for the N-bit ALU and its control stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    MOD = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Active-low hex digit to 7-segment decoder (bit 6 = g ... bit 0 = a).
// Only present when SEVEN_SEG_EN is defined.
`ifdef SEVEN_SEG_EN
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Control stage for the N-bit ALU: latch request, wait op latency, register result/flags, pulse valid.
// Optional registered 7-segment output of the result when SEVEN_SEG_EN is defined.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MULT_LAT = 5,
  parameter  int COMB_LAT = 1,
  localparam int SW       = $clog2(N) + 1,
  localparam int CW       = $clog2(MULT_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    opcode,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  input  logic [SW-1:0] shamt_in,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic [SW-1:0] shift_amount,
  output logic          alu_rst,
  input  logic [N-1:0]  sum_out,
  input  logic [N-1:0]  D,
  input  logic [N-1:0]  mult_out,
  input  logic [N-1:0]  quotient,
  input  logic [N-1:0]  mod_out,
  input  logic [N-1:0]  and_out,
  input  logic [N-1:0]  or_out,
  input  logic [N-1:0]  xor_out,
  input  logic [N-1:0]  shift_left_out,
  input  logic [N-1:0]  shift_right_out,
  input  logic          carry_out_sum,
  input  logic          overflow_sum,
  input  logic          Cout_rest,
  input  logic          V_rest,
  input  logic          C_mult,
  input  logic          V_mult,
  output logic          busy,
  output logic          valid,
  output logic [N-1:0]  result,
  output logic          Z,
  output logic          N_f,
  output logic          C,
  output logic          V,
  output logic          err,
  output logic [6:0]    seg
);

  state_e        state, state_next;
  alu_op_e       op_q;
  logic [CW-1:0] cnt;
  logic          accept, capture;
  logic [N-1:0]  cap_res;
  logic          cap_c, cap_v, cap_err;

  assign accept  = (state == IDLE) && start;
  // Illegal opcodes capture straight from IDLE; legal ones at the end of WAIT.
  assign capture = (state == WAIT && cnt == '0) || (accept && !op_legal(opcode));

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = op_legal(opcode) ? LOAD : DONE;
      LOAD:    state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == LOAD) || (state == WAIT);
    valid   = (state == DONE);
    alu_rst = rst || (state == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A            <= '0;
      B            <= '0;
      shift_amount <= '0;
      op_q         <= ADD;
      cnt          <= '0;
    end else begin
      if (accept) begin
        A            <= a_in;
        B            <= b_in;
        shift_amount <= shamt_in;
        op_q         <= alu_op_e'(opcode);
      end
      if (state == LOAD)
        cnt <= (op_q == MUL) ? CW'(MULT_LAT - 1) : CW'(COMB_LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    cap_res = '0;
    cap_c   = 1'b0;
    cap_v   = 1'b0;
    cap_err = 1'b0;
    if (state == IDLE) begin
      cap_err = 1'b1;
    end else begin
      case (op_q)
        ADD: begin cap_res = sum_out;          cap_c = carry_out_sum; cap_v = overflow_sum; end
        SUB: begin cap_res = D;                cap_c = Cout_rest;     cap_v = V_rest;       end
        MUL: begin cap_res = mult_out[N-1:0];  cap_c = C_mult;        cap_v = V_mult;       end
        DIV: begin
          cap_err = (B == '0);
          cap_res = cap_err ? '1 : quotient;
        end
        MOD: begin
          cap_err = (B == '0);
          cap_res = cap_err ? '1 : mod_out;
        end
        AND:     cap_res = and_out;
        OR:      cap_res = or_out;
        XOR:     cap_res = xor_out;
        SHL:     cap_res = shift_left_out;
        SHR:     cap_res = shift_right_out;
        default: cap_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      Z      <= 1'b0;
      N_f    <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      err    <= 1'b0;
    end else if (capture) begin
      result <= cap_res;
      Z      <= (cap_res == '0);
      N_f    <= cap_res[N-1];
      C      <= cap_c;
      V      <= cap_v;
      err    <= cap_err;
    end
  end

`ifdef SEVEN_SEG_EN
  logic [6:0] seg_d;

  hex_to_7seg u_hex_to_7seg (
    .hex (4'(cap_res)),
    .seg (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst)          seg <= 7'h7F;
    else if (capture) seg <= seg_d;
  end
`else
  assign seg = 7'h7F;
`endif

endmodule
